// File: rtl/fc_pkg.sv
// Shared types and elaboration-time helpers for the tiled fully-connected engine.
package fc_pkg;

  localparam int unsigned SHIFT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int unsigned ng_f(input int unsigned in_dim, input int unsigned lanes);
    return in_dim / lanes;
  endfunction

  function automatic int unsigned tree_lat_f(input int unsigned lanes);
    return clog2(lanes);
  endfunction

  // Tag delay from the issue register to the tree output.
  function automatic int unsigned lat_f(input int unsigned mul_lat, input int unsigned lanes);
    return 1 + mul_lat + tree_lat_f(lanes);
  endfunction

endpackage

// File: rtl/fc_tiled_engine_adder_tree.sv
// Pipelined signed adder tree: one register per level, LANES inputs reduced to one sum.
module adder_tree_p
  import fc_pkg::*;
#(
  parameter int unsigned LANES = 128,
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [LANES*IN_W-1:0]   operands,
  output logic signed [OUT_W-1:0] sum
);

  localparam int unsigned LVLS  = tree_lat_f(LANES);
  localparam int unsigned SUM_W = IN_W + LVLS;

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic signed [SUM_W-1:0] node [LANES>>l];

    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LANES; i++) begin : g_ext
        assign node[i] = SUM_W'($signed(operands[i*IN_W +: IN_W]));
      end
    end else begin : g_add
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          for (int k = 0; k < (LANES >> l); k++) node[k] <= '0;
        end else begin
          for (int k = 0; k < (LANES >> l); k++)
            node[k] <= g_lvl[l-1].node[2*k] + g_lvl[l-1].node[2*k+1];
        end
      end
    end
  end

  assign sum = OUT_W'(g_lvl[LVLS].node[0]);

endmodule

// File: rtl/fc_tiled_engine.sv
// Fully-connected layer sequencer: issues (channel, group) pairs to an external
// multiplier array, reduces and accumulates the products, requantises and writes back.
module fc_tiled_engine
  import fc_pkg::*;
#(
  parameter int unsigned IN_DIM  = 256,
  parameter int unsigned OUT_DIM = 32,
  parameter int unsigned LANES   = 128,
  parameter int unsigned ACT_W   = 4,
  parameter int unsigned W_W     = 8,
  parameter int unsigned PROD_W  = 25,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned MUL_LAT = 1,
  localparam int unsigned NG     = ng_f(IN_DIM, LANES),
  localparam int unsigned WA_W   = idx_w(OUT_DIM * NG),
  localparam int unsigned CH_W   = idx_w(OUT_DIM)
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic                      relu_en_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic [IN_DIM*ACT_W-1:0]   act_i,
  output logic [WA_W-1:0]           weight_addr_o,
  input  logic [LANES*W_W-1:0]      weight_i,
  output logic [CH_W-1:0]           bias_addr_o,
  input  logic [W_W-1:0]            bias_i,
  output logic [LANES*ACT_W-1:0]    mul_data1_o,
  output logic [LANES*W_W-1:0]      mul_data2_o,
  input  logic [LANES*PROD_W-1:0]   mul_result_i,
  output logic                      out_wren_o,
  output logic [CH_W-1:0]           out_addr_o,
  output logic [OUT_W-1:0]          out_data_o
);

  localparam int unsigned L     = lat_f(MUL_LAT, LANES);
  localparam int unsigned GRP_W = idx_w(NG);
  localparam int unsigned SL_W  = LANES * ACT_W;

  state_e state, state_nx;

  logic               accept, issue, last_grp, last_ch, pending;
  logic [CH_W-1:0]    ch;
  logic [GRP_W-1:0]   grp;
  logic               relu_q;
  logic [SHIFT_W-1:0] shift_q;

  logic               iss_vld, iss_first, iss_last;
  logic [CH_W-1:0]    iss_ch;
  logic [GRP_W-1:0]   iss_grp;

  logic [L-1:0]       tq_vld, tq_first, tq_last;
  logic [CH_W-1:0]    tq_ch [L];
  logic signed [W_W-1:0] bias_d [L-1];

  logic signed [ACC_W-1:0] sum, acc, bias_q, q_sum, q_shr;
  logic                    fin_vld;
  logic [CH_W-1:0]         fin_ch;
  logic [OUT_W-1:0]        q_out;
  logic [SL_W-1:0]         act_grp [NG];

  assign accept   = (state == IDLE) && start_i;
  assign issue    = (state == ISSUE);
  assign last_grp = (grp == GRP_W'(NG - 1));
  assign last_ch  = (ch == CH_W'(OUT_DIM - 1));
  assign pending  = iss_vld || (|tq_vld) || fin_vld;

  assign mul_data2_o = weight_i;

  for (genvar g = 0; g < NG; g++) begin : g_slice
    assign act_grp[g] = act_i[g*SL_W +: SL_W];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start_i) state_nx = ISSUE;
      ISSUE:   if (last_grp && last_ch) state_nx = DRAIN;
      DRAIN:   if (!pending) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Issue side: run-time settings, pair counters, memory addresses and the issue tag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      relu_q        <= 1'b0;
      shift_q       <= '0;
      ch            <= '0;
      grp           <= '0;
      iss_vld       <= 1'b0;
      iss_first     <= 1'b0;
      iss_last      <= 1'b0;
      iss_ch        <= '0;
      iss_grp       <= '0;
      weight_addr_o <= '0;
      bias_addr_o   <= '0;
    end else begin
      busy_o  <= (state_nx == ISSUE) || (state_nx == DRAIN);
      done_o  <= (state_nx == DONE);
      iss_vld <= issue;
      if (accept) begin
        relu_q  <= relu_en_i;
        shift_q <= shift_i;
        ch      <= '0;
        grp     <= '0;
      end
      if (issue) begin
        iss_first     <= (grp == '0);
        iss_last      <= last_grp;
        iss_ch        <= ch;
        iss_grp       <= grp;
        weight_addr_o <= WA_W'(32'(ch) * NG + 32'(grp));
        bias_addr_o   <= ch;
        if (last_grp) begin
          grp <= '0;
          ch  <= last_ch ? '0 : ch + CH_W'(1);
        end else begin
          grp <= grp + GRP_W'(1);
        end
      end
    end
  end

  adder_tree_p #(
    .LANES (LANES),
    .IN_W  (PROD_W),
    .OUT_W (ACC_W)
  ) u_tree (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .operands (mul_result_i),
    .sum      (sum)
  );

  // Negative values clamp to zero whether or not ReLU is on.
  always_comb begin
    q_sum = acc + bias_q;
    q_shr = q_sum >>> shift_q;
    q_out = OUT_W'(q_shr);
    if (q_shr[ACC_W-1] && relu_q)   q_out = '0;
    else if (q_shr[ACC_W-1])        q_out = '0;
    else if (|q_shr[ACC_W-2:OUT_W]) q_out = '1;
  end

  // Return side: tag/bias alignment, accumulation and the write-back register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mul_data1_o <= '0;
      tq_vld      <= '0;
      tq_first    <= '0;
      tq_last     <= '0;
      for (int i = 0; i < L; i++)     tq_ch[i]  <= '0;
      for (int i = 0; i < L - 1; i++) bias_d[i] <= '0;
      acc         <= '0;
      bias_q      <= '0;
      fin_vld     <= 1'b0;
      fin_ch      <= '0;
      out_wren_o  <= 1'b0;
      out_addr_o  <= '0;
      out_data_o  <= '0;
    end else begin
      mul_data1_o <= act_grp[iss_grp];
      tq_vld      <= {tq_vld[L-2:0], iss_vld};
      tq_first    <= {tq_first[L-2:0], iss_first};
      tq_last     <= {tq_last[L-2:0], iss_last};
      tq_ch[0]    <= iss_ch;
      for (int i = 1; i < L; i++)     tq_ch[i]  <= tq_ch[i-1];
      bias_d[0]   <= bias_i;
      for (int i = 1; i < L - 1; i++) bias_d[i] <= bias_d[i-1];
      fin_vld     <= tq_vld[L-1] && tq_last[L-1];
      if (tq_vld[L-1]) begin
        acc <= tq_first[L-1] ? sum : acc + sum;
        if (tq_last[L-1]) begin
          fin_ch <= tq_ch[L-1];
          bias_q <= ACC_W'(bias_d[L-2]);
        end
      end
      out_wren_o <= fin_vld;
      if (fin_vld) begin
        out_addr_o <= fin_ch;
        out_data_o <= q_out;
      end
    end
  end

endmodule

// File: tb/tb_fc_tiled_engine.sv
// Randomised bench for fc_tiled_engine with weight/bias memories, multiplier array and a dot-product model.
module tb_fc_tiled_engine;

  localparam int unsigned IN_DIM  = 8;
  localparam int unsigned OUT_DIM = 3;
  localparam int unsigned LANES   = 4;
  localparam int unsigned ACT_W   = 4;
  localparam int unsigned W_W     = 8;
  localparam int unsigned PROD_W  = 25;
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned OUT_W   = 4;
  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned NG      = IN_DIM / LANES;
  localparam int unsigned L       = 1 + MUL_LAT + 2;
  localparam int unsigned WA_W    = 3;
  localparam int unsigned CH_W    = 2;
  localparam int          OMAX    = 15;

  logic                     clk, rst_n, start, relu_en;
  logic [4:0]               shift;
  logic                     busy, done;
  logic [IN_DIM*ACT_W-1:0]  act;
  logic [WA_W-1:0]          weight_addr;
  logic [LANES*W_W-1:0]     weight_i;
  logic [CH_W-1:0]          bias_addr;
  logic [W_W-1:0]           bias_i;
  logic [LANES*ACT_W-1:0]   mul_data1;
  logic [LANES*W_W-1:0]     mul_data2;
  logic [LANES*PROD_W-1:0]  mul_result;
  logic                     out_wren;
  logic [CH_W-1:0]          out_addr;
  logic [OUT_W-1:0]         out_data;

  logic [LANES*W_W-1:0]     wrow [OUT_DIM*NG];
  logic [W_W-1:0]           bmem [OUT_DIM];

  int checks = 0;
  int errors = 0;
  int expv [OUT_DIM];
  bit scramble = 1'b0;

  fc_tiled_engine #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .LANES(LANES), .ACT_W(ACT_W), .W_W(W_W),
    .PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .relu_en_i(relu_en), .shift_i(shift),
    .busy_o(busy), .done_o(done), .act_i(act),
    .weight_addr_o(weight_addr), .weight_i(weight_i),
    .bias_addr_o(bias_addr), .bias_i(bias_i),
    .mul_data1_o(mul_data1), .mul_data2_o(mul_data2), .mul_result_i(mul_result),
    .out_wren_o(out_wren), .out_addr_o(out_addr), .out_data_o(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LANES*PROD_W-1:0] mul_f(input logic [LANES*ACT_W-1:0] a,
                                                    input logic [LANES*W_W-1:0] w);
    logic [LANES*PROD_W-1:0] r;
    logic [ACT_W-1:0]        aj;
    logic signed [W_W-1:0]   wj;
    int                      p;
    for (int j = 0; j < LANES; j++) begin
      aj = a[j*ACT_W +: ACT_W];
      wj = w[j*W_W +: W_W];
      p  = int'(aj) * int'(wj);
      r[j*PROD_W +: PROD_W] = PROD_W'(p);
    end
    return r;
  endfunction

  // Synchronous-read memories and the external one-cycle multiplier array.
  always @(posedge clk) begin
    weight_i   <= wrow[weight_addr];
    bias_i     <= bmem[bias_addr];
    mul_result <= mul_f(mul_data1, mul_data2);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int act_at(input int k);
    logic [ACT_W-1:0] a;
    a = act[k*ACT_W +: ACT_W];
    return int'(a);
  endfunction

  function automatic int w_at(input int c, input int k);
    logic [LANES*W_W-1:0]  r;
    logic signed [W_W-1:0] w;
    r = wrow[c*NG + k/LANES];
    w = r[(k%LANES)*W_W +: W_W];
    return int'(w);
  endfunction

  function automatic int b_at(input int c);
    logic signed [W_W-1:0] b;
    b = bmem[c];
    return int'(b);
  endfunction

  task automatic set_w(input int c, input int k, input int v);
    logic [LANES*W_W-1:0] r;
    r = wrow[c*NG + k/LANES];
    r[(k%LANES)*W_W +: W_W] = W_W'(v);
    wrow[c*NG + k/LANES] = r;
  endtask

  task automatic fill(input int a, input int w0, input int w1, input int w2, input int b0,
                      input int b1, input int b2);
    for (int k = 0; k < IN_DIM; k++) begin
      act[k*ACT_W +: ACT_W] = ACT_W'(a);
      set_w(0, k, w0);
      set_w(1, k, w1);
      set_w(2, k, w2);
    end
    bmem[0] = W_W'(b0);
    bmem[1] = W_W'(b1);
    bmem[2] = W_W'(b2);
  endtask

  task automatic rand_fill();
    for (int k = 0; k < IN_DIM; k++) begin
      act[k*ACT_W +: ACT_W] = ACT_W'($urandom_range(0, 15));
      for (int c = 0; c < OUT_DIM; c++) set_w(c, k, int'($urandom_range(0, 255)) - 128);
    end
    for (int c = 0; c < OUT_DIM; c++) bmem[c] = W_W'($urandom_range(0, 255));
  endtask

  // Reference: flat dot product plus bias, arithmetic shift, clamp to the output range.
  task automatic compute_exp(input bit relu, input int sh);
    int s;
    for (int c = 0; c < OUT_DIM; c++) begin
      s = 0;
      for (int k = 0; k < IN_DIM; k++) s += act_at(k) * w_at(c, k);
      s += b_at(c);
      s = s >>> sh;
      if (relu && s < 0) s = 0;
      else if (s < 0)    s = 0;
      else if (s > OMAX) s = OMAX;
      expv[c] = s;
    end
  endtask

  task automatic start_run(input bit relu, input int sh, input bit hold);
    @(posedge clk); #1;
    relu_en = relu;
    shift   = 5'(sh);
    start   = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Follows one run from just after its accepting edge to one cycle past done.
  task automatic collect();
    int cyc, nwr, ndone, first;
    bit gap;
    cyc = 0; nwr = 0; ndone = 0; first = -1; gap = 1'b0;
    while (ndone == 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (scramble) begin
        relu_en = 1'($urandom);
        shift   = 5'($urandom);
      end
      if (out_wren) begin
        if (nwr < OUT_DIM) begin
          chk("wr_addr", out_addr, nwr);
          chk("wr_data", out_data, expv[nwr]);
        end
        if (first < 0) first = cyc;
        nwr++;
      end
      if (done) begin
        ndone++;
        chk("busy_at_done", busy, 0);
      end else if (!busy) begin
        gap = 1'b1;
      end
    end
    chk("done_seen", ndone, 1);
    chk("n_writes", nwr, OUT_DIM);
    chk("busy_cont", gap, 0);
    chk("first_wr_lat", first, NG + L + 2);
    @(posedge clk); #1;
    chk("done_once", done, 0);
  endtask

  initial begin
    int nbad;
    bit r;
    int sh;
    rst_n = 1'b0; start = 1'b0; relu_en = 1'b0; shift = '0; act = '0;
    for (int i = 0; i < OUT_DIM*NG; i++) wrow[i] = '0;
    for (int i = 0; i < OUT_DIM; i++) bmem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", out_wren, 0);
    chk("rst_oaddr", out_addr, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_waddr", weight_addr, 0);
    chk("rst_baddr", bias_addr, 0);
    @(negedge clk) rst_n = 1'b1;

    fill(1, 1, 1, 1, 0, 0, 0);
    compute_exp(1'b1, 0);
    start_run(1'b1, 0, 1'b0);
    collect();

    fill(1, 1, -1, 1, 3, 3, 3);
    compute_exp(1'b0, 0);
    start_run(1'b0, 0, 1'b0);
    collect();
    compute_exp(1'b1, 0);
    start_run(1'b1, 0, 1'b0);
    collect();

    fill(5, 1, 5, 0, 10, 0, -8);
    compute_exp(1'b0, 2);
    start_run(1'b0, 2, 1'b0);
    collect();

    repeat (4) begin
      rand_fill();
      r  = 1'($urandom);
      sh = int'($urandom_range(0, 10));
      compute_exp(r, sh);
      start_run(r, sh, 1'b0);
      collect();
    end

    // start held high across a run while relu/shift wander.
    rand_fill();
    sh = int'($urandom_range(0, 8));
    compute_exp(1'b0, sh);
    start_run(1'b0, sh, 1'b1);
    scramble = 1'b1;
    collect();
    scramble = 1'b0;
    chk("gap_busy", busy, 0);
    sh = int'($urandom_range(0, 8));
    relu_en = 1'b1;
    shift   = 5'(sh);
    compute_exp(1'b1, sh);
    @(posedge clk); #1;
    chk("rerun_busy", busy, 1);
    start = 1'b0;
    collect();

    // Asynchronous abort while channel 1 is being issued.
    rand_fill();
    start_run(1'b0, 3, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_wren", out_wren, 0);
    chk("abort_oaddr", out_addr, 0);
    chk("abort_odata", out_data, 0);
    chk("abort_waddr", weight_addr, 0);
    chk("abort_baddr", bias_addr, 0);
    chk("abort_mul1", mul_data1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nbad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_wren || done || busy) nbad++;
    end
    chk("quiet_after_abort", nbad, 0);

    rand_fill();
    sh = int'($urandom_range(0, 10));
    compute_exp(1'b1, sh);
    start_run(1'b1, sh, 1'b0);
    collect();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_tiled_engine.md
Name: fc_tiled_engine

Overview:
Parametrised fully-connected layer engine for the quantised inference datapath. Computes OUT_DIM outputs, each the dot product of a flat activation vector and one weight row, plus bias. The input vector is tiled into LANES-wide groups, and the group partial sums are accumulated per channel. The multiplier array is external; the block owns sequencing, weight/bias addressing, the adder tree, accumulation, requantisation (shift, optional ReLU, saturation) and output write-back.

Parameters:
IN_DIM, 256, input vector length; must be a multiple of LANES.
OUT_DIM, 32, number of output channels.
LANES, 128, products summed per cycle; power of two.
ACT_W, 4, activation width (unsigned).
W_W, 8, weight and bias width (signed).
PROD_W, 25, width of each external product (signed).
ACC_W, 32, accumulator width (signed).
OUT_W, 4, output width (unsigned).
MUL_LAT, 1, external multiplier latency in cycles.
Derived values: NG = IN_DIM/LANES; TREE_LAT = log2(LANES); WA_W = clog2(OUT_DIM*NG); CH_W = clog2(OUT_DIM).

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset; asynchronous, active-low
start_i  in  1  start pulse; accepted only in IDLE
relu_en_i  in  1  ReLU enable; latched at start
shift_i  in  5  arithmetic right-shift amount; latched at start
busy_o  out  1  high from start acceptance until done_o
done_o  out  1  one-cycle pulse after the final output write
act_i  in  IN_DIM*ACT_W  flat activation vector; element k is at bits [k*ACT_W +: ACT_W]; held stable while busy
weight_addr_o  out  WA_W  weight row address = ch*NG + grp
weight_i  in  LANES*W_W  weight data; 1-cycle read latency
bias_addr_o  out  CH_W  bias address = ch
bias_i  in  W_W  bias data; 1-cycle read latency
mul_data1_o  out  LANES*ACT_W  activation slice of the current group
mul_data2_o  out  LANES*W_W  weight_i passed through
mul_result_i  in  LANES*PROD_W  products; valid MUL_LAT cycles after operands
out_wren_o  out  1  output write strobe
out_addr_o  out  CH_W  output channel index
out_data_o  out  OUT_W  requantised output

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE. Reset state is IDLE.
- Reset values: all outputs 0; counters, accumulator and tag pipeline cleared.
- IDLE -> ISSUE on start_i. On that edge: latch relu_en_i and shift_i, set busy_o=1, clear ch and grp.
- start_i while busy is ignored.
- ISSUE issues one (ch, grp) pair per cycle, grp varying fastest.
  - Each issue registers weight_addr_o and bias_addr_o and pushes a tag {valid, first=(grp==0), last=(grp==NG-1), ch}.
  - After pair (OUT_DIM-1, NG-1) the state goes to DRAIN.
  - Total issue cycles = OUT_DIM*NG.
- mul_data1_o is act_i sliced by the grp value aligned with weight_i (grp delayed 1 cycle). The activation slice and weight of a pair must reach the multiplier in the same cycle.
- Adder tree: TREE_LAT registered levels with sign extension at each level. The final sum is sign-extended or truncated to ACC_W.
- Tag pipeline depth L = 1 + MUL_LAT + TREE_LAT, so each tag aligns with its tree sum.
- Accumulator (one register, since a channel's groups are consecutive): acc <= first ? sum : acc + sum. Wraps modulo 2^ACC_W; no saturation.
- Bias: bias_i is delayed to align with the last-group tag of its channel. It is sign-extended to ACC_W and added once per channel, to the final accumulated value.
- Requantisation stage (registered): v = (acc_final + bias) >>> shift_i.
  - If relu_en and v < 0, then v = 0.
  - Otherwise saturate to [0, 2^OUT_W-1]; negative v with ReLU off also saturates to 0.
- Write: out_wren_o=1 for exactly one cycle per channel, with out_addr_o=ch and out_data_o=v.
  - Write latency from issuing a channel's last group = L + 2 cycles.
  - Writes occur in ascending channel order, OUT_DIM writes per run.
- DRAIN -> DONE when the tag pipeline is empty and the last write has occurred.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, then IDLE.
- Back-to-back operation: start_i asserted in the cycle done_o is high is not accepted. Earliest accepted start is the following cycle.
- NG=1 is legal: every tag is both first and last.
- Reset mid-run: asynchronous abort to IDLE. No write and no done_o occur afterwards; partial results are discarded.

Decomposition:
- Shared package fc_pkg: state encodings, the clog2 function, and NG/TREE_LAT/L derivation helpers.
- Sub-module adder_tree_p:
  - Parameters: LANES, IN_W, OUT_W.
  - Contents: pipelined, one register per level, latency TREE_LAT.
  - Instantiated once.

Test Plan:
All cases use IN_DIM=8, LANES=4, OUT_DIM=3, MUL_LAT=1, shift=0, unless stated otherwise.
- All activations 1, all weights 1, bias 0, relu on -> three writes of value 8 (saturated to 15 if larger), addresses 0,1,2 in order, done_o pulses once.
- Row 1 weights = -1, bias=+3, act=1, relu off -> ch1 sum -5 saturates to 0; set relu on -> still 0; ch0 (weights 1, bias 3) -> 11.
- shift_i=2, sum+bias=50 -> out 12; sum+bias=200 -> saturates to 15.
- Timing check: first out_wren_o exactly NG + L + 2 cycles after the accepting edge; busy_o high continuously until done_o.
- start_i held high throughout a run -> exactly one run executes; a second run begins only in the cycle after done_o; relu/shift values changed mid-run have no effect.
- rst_n_i asserted during ISSUE of ch1 -> all outputs 0 immediately; no further writes; a new start then completes normally with correct values.
